// File: rtl/tpu_pkg.sv
// Shared types and geometry for the convolution sequencer.
// Window count depends on CONV_PAD_EN (zero "same" padding when defined).
package tpu_pkg;

    localparam int CFG_MATRIX_DIM = 16;
    localparam int CFG_CONV_DIM   = 3;
    localparam int MW             = $clog2(CFG_MATRIX_DIM);
    localparam int KW             = $clog2(CFG_CONV_DIM);
    localparam int N_TAPS         = CFG_CONV_DIM * CFG_CONV_DIM;

`ifdef CONV_PAD_EN
    localparam int OUT_DIM = CFG_MATRIX_DIM;
`else
    localparam int OUT_DIM = CFG_MATRIX_DIM - CFG_CONV_DIM + 1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        LOAD_M,
        TAP,
        HOLD,
        FIN
    } seq_state_t;

    typedef struct packed {
        logic [KW-1:0] x;
        logic [KW-1:0] y;
    } conv_coord_t;

    // One bit wider than a matrix address so off-edge taps show up as negative.
    typedef struct packed {
        logic signed [MW:0] x;
        logic signed [MW:0] y;
    } base_coord_t;

endpackage

// File: rtl/conv_window_walker.sv
// Nested tap and base counters (x fastest); used for both load ordering and window walking.
// base_last selects the base range: full matrix while loading, last window origin while computing.
module conv_window_walker
    import tpu_pkg::*;
#(
    parameter int CONV_DIM = CFG_CONV_DIM
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tap_clr,
    input  logic          tap_step,
    input  logic          base_clr,
    input  logic          base_step,
    input  logic [MW-1:0] base_last,
    output conv_coord_t   tap,
    output logic [MW-1:0] base_x,
    output logic [MW-1:0] base_y,
    output logic          last_tap,
    output logic          last_window
);

    localparam logic [KW-1:0] TAP_LAST = KW'(CONV_DIM - 1);

    assign last_tap    = (tap.x == TAP_LAST) && (tap.y == TAP_LAST);
    assign last_window = (base_x == base_last) && (base_y == base_last);

    // NOTE: sequential state uses non-blocking assignments so every counter
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap <= '0;
        end else if (tap_clr) begin
            tap <= '0;
        end else if (tap_step) begin
            if (tap.x == TAP_LAST) begin
                tap.x <= '0;
                tap.y <= (tap.y == TAP_LAST) ? '0 : tap.y + 1'b1;
            end else begin
                tap.x <= tap.x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_x <= '0;
            base_y <= '0;
        end else if (base_clr) begin
            base_x <= '0;
            base_y <= '0;
        end else if (base_step) begin
            if (base_x == base_last) begin
                base_x <= '0;
                base_y <= (base_y == base_last) ? '0 : base_y + 1'b1;
            end else begin
                base_x <= base_x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Control FSM for the convolution datapath: loads kernel/matrix, walks windows, hands out results.
// Define CONV_PAD_EN for zero ("same") padding; default build computes valid-only windows.
module conv_sequencer
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MATRIX_DIM = CFG_MATRIX_DIM,
    parameter int CONV_DIM   = CFG_CONV_DIM
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          keep_kernel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          k_we,
    output logic [KW-1:0] k_x,
    output logic [KW-1:0] k_y,
    output logic          m_we,
    output logic [MW-1:0] m_x,
    output logic [MW-1:0] m_y,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          pad_zero,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    seq_state_t    state, state_next;
    conv_coord_t   tap;
    logic [MW-1:0] base_x, base_y, base_last;
    logic          last_tap, last_window;
    logic          tap_clr, tap_step, base_clr, base_step;

    assign base_last = (state == LOAD_M) ? MW'(MATRIX_DIM - 1) : MW'(OUT_DIM - 1);
    assign busy      = (state != IDLE);

    conv_window_walker #(.CONV_DIM(CONV_DIM)) u_walker (
        .clk         (clk),
        .rst         (rst),
        .tap_clr     (tap_clr),
        .tap_step    (tap_step),
        .base_clr    (base_clr),
        .base_step   (base_step),
        .base_last   (base_last),
        .tap         (tap),
        .base_x      (base_x),
        .base_y      (base_y),
        .last_tap    (last_tap),
        .last_window (last_window)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        k_we       = 1'b0;
        m_we       = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        tap_clr    = 1'b0;
        tap_step   = 1'b0;
        base_clr   = 1'b0;
        base_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    tap_clr    = 1'b1;
                    base_clr   = 1'b1;
                    state_next = keep_kernel ? LOAD_M : LOAD_K;
                end
            end
            LOAD_K: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    k_we     = 1'b1;
                    tap_step = 1'b1;
                    if (last_tap) state_next = LOAD_M;
                end
            end
            LOAD_M: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m_we      = 1'b1;
                    base_step = 1'b1;
                    if (last_window) state_next = TAP;
                end
            end
            TAP: begin
                mac_en   = 1'b1;
                mac_clr  = (tap.x == '0) && (tap.y == '0);
                tap_step = 1'b1;
                if (last_tap) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    base_step  = 1'b1;
                    state_next = last_window ? FIN : TAP;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef CONV_PAD_EN
    localparam logic [MW:0] PAD = (MW + 1)'((CONV_DIM - 1) / 2);
    base_coord_t pos;

    // Top overflow (up to MATRIX_DIM-1+PAD) wraps into the negative half, so the
    // sign bit alone flags any tap outside the matrix.
    always_comb begin
        pos.x = {1'b0, base_x} + (MW + 1)'(tap.x) - PAD;
        pos.y = {1'b0, base_y} + (MW + 1)'(tap.y) - PAD;
    end
`endif

    always_comb begin
        k_x      = '0;
        k_y      = '0;
        m_x      = '0;
        m_y      = '0;
        pad_zero = 1'b0;
        case (state)
            LOAD_K: begin
                k_x = tap.x;
                k_y = tap.y;
            end
            LOAD_M: begin
                m_x = base_x;
                m_y = base_y;
            end
            TAP: begin
                k_x = tap.x;
                k_y = tap.y;
`ifdef CONV_PAD_EN
                if (pos.x[MW] || pos.y[MW]) begin
                    pad_zero = 1'b1;
                end else begin
                    m_x = pos.x[MW-1:0];
                    m_y = pos.y[MW-1:0];
                end
`else
                m_x = base_x + MW'(tap.x);
                m_y = base_y + MW'(tap.y);
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: randomized load/handshake stimulus against a
// window-sum reference model; honours CONV_PAD_EN when defined.
module tb_conv_sequencer;

    localparam int M  = 16;
    localparam int C  = 3;
    localparam int NT = C * C;
`ifdef CONV_PAD_EN
    localparam int OUT = M;
    localparam int P   = (C - 1) / 2;
`else
    localparam int OUT = M - C + 1;
    localparam int P   = 0;
`endif
    localparam int N_WIN = OUT * OUT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       keep_kernel = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, k_we, m_we, mac_clr, mac_en, pad_zero, out_valid, busy, done;
    logic [1:0] k_x, k_y;
    logic [3:0] m_x, m_y;

    conv_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .keep_kernel (keep_kernel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .k_we        (k_we),
        .k_x         (k_x),
        .k_y         (k_y),
        .m_we        (m_we),
        .m_x         (m_x),
        .m_y         (m_y),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .pad_zero    (pad_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stream data, reference contents, and the register files as written by DUT addresses.
    logic [7:0] ldk [NT];
    logic [7:0] ldm [M*M];
    logic [7:0] kref [NT];
    logic [7:0] mref [M*M];
    logic [7:0] kmem [16];
    logic [7:0] mmem [M*M];

    int   kbeat, mbeat, tap_idx, win_idx, done_seen, last_hs, hold_cyc;
    int   cyc = 0;
    int   iv_mode = 0;
    int   or_mode = 0;
    int   hold_left = 0;
    bit   hold_pending = 0;
    bit   hold_flag = 0;
    bit   spacing_on = 0;
    bit   pattern1 = 0;
    bit   exp_tap_start = 0;
    logic [7:0] acc = '0;

    function automatic int ref_result(input int w);
        int bx, by, x, y, s;
        bx = w % OUT;
        by = w / OUT;
        s  = 0;
        for (int ky = 0; ky < C; ky++) begin
            for (int kx = 0; kx < C; kx++) begin
                x = bx + kx - P;
                y = by + ky - P;
                if (x >= 0 && x < M && y >= 0 && y < M)
                    s += int'(kref[ky*C + kx]) * int'(mref[y*M + x]);
            end
        end
        return s % 256;
    endfunction

    always @(negedge clk) begin
        int kx, ky, bx, by, ex, ey, pad, kidx, midx;
        logic [15:0] prod;
        cyc++;
        if (rst) begin
            check("we_handshake", 32'(k_we | m_we), 32'(in_valid & in_ready));
            kidx = int'(k_y) * C + int'(k_x);
            midx = int'(m_y) * M + int'(m_x);
            if (k_we) begin
                check("k_load_addr", 32'(kidx), 32'(kbeat));
                kmem[kidx] = ldk[kbeat % NT];
                kbeat++;
            end
            if (m_we) begin
                check("m_load_addr", 32'(midx), 32'(mbeat));
                mmem[midx] = ldm[mbeat % (M*M)];
                mbeat++;
            end
            if (exp_tap_start) begin
                check("next_win_start", 32'(mac_en & mac_clr), 32'd1);
                exp_tap_start = 0;
            end
            if (hold_flag) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                hold_cyc++;
            end
            bx = win_idx % OUT;
            by = (win_idx / OUT) % OUT;
            if (mac_en) begin
                kx  = tap_idx % C;
                ky  = (tap_idx / C) % C;
                ex  = bx + kx - P;
                ey  = by + ky - P;
                pad = (ex < 0 || ex >= M || ey < 0 || ey >= M) ? 1 : 0;
                check("tap_k_addr", 32'(kidx), 32'(ky*C + kx));
                check("tap_first", 32'(mac_clr), 32'(tap_idx == 0));
                check("tap_pad", 32'(pad_zero), 32'(pad));
                check("tap_m_addr", 32'(midx), 32'(pad ? 0 : ey*M + ex));
                check("tap_in_ready", 32'(in_ready), 32'd0);
                prod = kmem[kidx] * (pad_zero ? 8'd0 : mmem[midx]);
                acc  = mac_clr ? prod[7:0] : 8'(acc + prod[7:0]);
                tap_idx++;
            end
            if (out_valid) begin
                check("hold_no_mac", 32'(mac_en), 32'd0);
                if (out_ready) begin
                    check("taps_per_win", 32'(tap_idx), 32'(NT));
                    check("result", 32'(acc), 32'(ref_result(win_idx)));
`ifndef CONV_PAD_EN
                    if (pattern1) check("ones_formula", 32'(acc), 32'((3*(3*bx + 3)) % 256));
`endif
                    if (spacing_on && win_idx > 0)
                        check("result_spacing", 32'(cyc - last_hs), 32'(NT + 1));
                    last_hs = cyc;
                    win_idx++;
                    tap_idx = 0;
                    exp_tap_start = (win_idx < N_WIN);
                end
            end
            if (done) begin
                check("done_windows", 32'(win_idx), 32'(N_WIN));
                check("done_latency", 32'(cyc - last_hs), 32'd1);
                check("done_busy", 32'(busy), 32'd1);
                done_seen++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (iv_mode)
            0:       in_valid = 1'b1;
            1:       in_valid = ~in_valid;
            default: in_valid = 1'($urandom_range(0, 1));
        endcase
        if (hold_pending && out_valid) begin
            hold_pending = 0;
            hold_left    = 20;
        end
        if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
            hold_flag = 1;
        end else begin
            hold_flag = 0;
            out_ready = (or_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic reset_monitor();
        kbeat = 0; mbeat = 0; tap_idx = 0; win_idx = 0;
        done_seen = 0; hold_cyc = 0; last_hs = 0; exp_tap_start = 0;
    endtask

    task automatic prepare(input bit keep, input int pat);
        for (int i = 0; i < NT; i++) begin
            ldk[i] = (pat == 1) ? 8'd1 : 8'($urandom);
            if (!keep) kref[i] = ldk[i];
        end
        for (int i = 0; i < M*M; i++) begin
            ldm[i]  = (pat == 1) ? 8'(i % M) : 8'($urandom);
            mref[i] = ldm[i];
        end
    endtask

    task automatic run_job(input bit keep, input int pat, input int ivm, input int orm,
                           input bit hold, input bit spacing);
        int  cnt;
        bit  poked;
        reset_monitor();
        iv_mode = ivm; or_mode = orm; pattern1 = (pat == 1);
        spacing_on = spacing; hold_pending = hold;
        prepare(keep, pat);
        keep_kernel = keep;
        start = 1'b1;
        step();
        start = 1'b0;
        keep_kernel = 1'b0;
        cnt = 0;
        poked = 0;
        while (done_seen == 0 && cnt < 20000) begin
            if (win_idx == 2 && !poked) begin
                start = 1'b1;
                keep_kernel = 1'($urandom_range(0, 1));
                poked = 1;
            end else begin
                start = 1'b0;
            end
            step();
            cnt++;
        end
        start = 1'b0;
        check("job_done", 32'(done_seen), 32'd1);
        check("k_beats", 32'(kbeat), keep ? 32'd0 : 32'(NT));
        check("m_beats", 32'(mbeat), 32'(M*M));
        if (hold) check("hold_cycles", 32'(hold_cyc), 32'd20);
        step();
        @(negedge clk);
        check("idle_after_job", 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt;
        reset_monitor();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ctrl", 32'({k_we, m_we, mac_en, mac_clr, pad_zero, out_valid, done}), 32'd0);
        check("rst_addr", 32'({k_x, k_y, m_x, m_y}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Kernel load with in_valid toggling, random stalls and a 20-cycle HOLD stall.
        run_job(1'b0, 0, 1, 1, 1'b1, 1'b0);
        // Reuse the stored kernel with a fresh random matrix.
        run_job(1'b1, 0, 2, 0, 1'b0, 1'b0);

        // Reset mid matrix load at beat 40.
        reset_monitor();
        prepare(1'b0, 0);
        iv_mode = 0; or_mode = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        cnt = 0;
        while (mbeat < 40 && cnt < 200) begin
            step();
            cnt++;
        end
        check("reach_beat40", 32'(mbeat), 32'd40);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_in_ready", 32'(in_ready), 32'd0);

        // Ones kernel, matrix(x,y)=x, full-rate consumer: fixed spacing between results.
        run_job(1'b0, 1, 0, 0, 1'b0, 1'b1);
        // Old (all-ones) kernel kept, random matrix and random consumer.
        run_job(1'b1, 0, 2, 1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
